sum_stationary_drain: RTL and testbench
=======================================

Name: sum_stationary_drain

Overview:
- Downstream stage of the sum-stationary NxN matrix engine.
- Captures the engine's full C result array in one cycle when the engine flags completion, then immediately clears the engine for the next product.
- Streams the captured result out one row (N elements) per beat over a valid/ready interface.
- Frees the engine to compute the next product while the previous result is still draining.

Parameters:
- DATA_WIDTH, 8, operand width used by the engine.
- N, 4, matrix dimension; minimum 1.
- C_DATA_WIDTH, 2*DATA_WIDTH+$clog2(N), width of one result element; must match the engine.

Ports:
- clk  input  1  clock.
- reset_ni  input  1  asynchronous active-low reset.
- mm_valid_i  input  1  engine result-complete flag (engine valid_o).
- c_i  input  [C_DATA_WIDTH-1:0] x [N][N]  engine result array (engine c_o).
- mm_clear_o  input-side control, output  1  one-cycle synchronous clear to engine reset_i.
- row_valid_o  output  1  row beat valid.
- row_ready_i  input  1  downstream accepts beat.
- row_data_o  output  [C_DATA_WIDTH-1:0] x [N]  current row.
- row_idx_o  output  max(1,$clog2(N))  index of current row.
- row_last_o  output  1  current beat is row N-1.
- busy_o  output  1  buffer holds an undrained result.

Behaviour:
- Reset (async assert, reset_ni=0):
  - state=IDLE; row counter=0; buffer contents are don't-care.
  - All outputs 0, including row_data_o.
  - Deassertion is synchronised by the integrator.
- States: IDLE, SEND.
- Capture event (cap) = mm_valid_i && (state==IDLE || (state==SEND && row_valid_o && row_ready_i && row_last_o)).
  - On cap: buffer <= c_i (all N*N elements, same edge); row counter <= 0; state <= SEND.
- mm_clear_o = cap, combinational (Mealy).
  - Engine clears on the same edge the buffer captures, so a stale mm_valid_i is never captured twice.
- mm_valid_i while in SEND without the last handshake is ignored. The engine holds its result (its valid_o freezes the array), and capture waits.
- SEND:
  - row_valid_o=1; row_data_o=buffer[row counter]; row_idx_o=row counter; row_last_o=(row counter==N-1).
  - Handshake (row_valid_o && row_ready_i): counter increments.
  - On the last handshake with no cap: state <= IDLE, counter <= 0.
  - On the last handshake with cap: stay in SEND at row 0 with the new data (back-to-back; no bubble).
- Output stability: row_data_o and row_idx_o must not change while row_valid_o=1 and row_ready_i=0.
- IDLE: row_valid_o=0, row_last_o=0, row_data_o=0.
- busy_o = (state==SEND).
- Latency:
  - mm_valid_i high in IDLE at edge k → row 0 valid after edge k.
  - Minimum drain is N cycles with row_ready_i held high.
- N=1: a single beat with row_last_o=1 and row_idx_o=0.
- No arithmetic; elements pass through bit-exact at C_DATA_WIDTH.
- Reset mid-SEND: the beat is dropped and the state returns to IDLE. The engine is not cleared by this block (mm_clear_o=0); system reset covers the engine.

Optional Feature:
- Macro SUM_STATIONARY_DRAIN_TRANSPOSE_EN.
- Defined: beat k carries column k, i.e. row_data_o[j]=buffer[j][k]; row_idx_o is the column index. Emits C transposed for column-major consumers.
- Undefined: row-major as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package sum_stationary_pkg holds:
  - drain_state_e enum {IDLE, SEND};
  - localparam function for the row-index width (max(1,$clog2(N)));
  - C_DATA_WIDTH derivation function shared with the engine.
- One sub-module, result_row_select: combinational N:1 row (or column, under the macro) selector from the buffer, driven by the row counter. Output is zeroed when not valid.
- FSM, counter and buffer stay in the top module.

Test Plan (N=4, DATA_WIDTH=8):
- Basic drain:
  - Stimulus: c_i[i][j]=10*i+j, mm_valid_i pulse, row_ready_i=1.
  - Required: mm_clear_o high exactly one cycle at capture; 4 consecutive beats, rows {0,1,2,3},{10..13},{20..23},{30..33}; row_last_o only on idx 3; then IDLE with busy_o=0.
- Backpressure:
  - Stimulus: row_ready_i low for 3 cycles during row 1.
  - Required: row_idx_o=1 and data {10,11,12,13} held stable; no beat lost or duplicated.
- Held engine:
  - Stimulus: second mm_valid_i with c_i=100+... asserted during row 1 and held.
  - Required: no mm_clear_o until the row-3 handshake; at that edge the clear and capture occur; row 0 of the new matrix follows with no idle cycle.
- Wide values:
  - Stimulus: c_i all set to 2^18-1 (C_DATA_WIDTH=18).
  - Required: outputs bit-exact 0x3FFFF.
- Async reset:
  - Stimulus: reset_ni dropped mid-row 2 between clock edges.
  - Required: row_valid_o and busy_o fall immediately; mm_clear_o=0; a later mm_valid_i restarts at row 0.
- Transpose build:
  - Stimulus: same as basic drain, with the macro defined.
  - Required: beats {0,10,20,30},{1,11,21,31},{2,12,22,32},{3,13,23,33}.

Source files
------------

// File: rtl/sum_stationary_pkg.sv
// Shared types and width helpers for the sum-stationary matrix engine and its drain stage.
package sum_stationary_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    // Row counter width; a single-row matrix still needs one bit.
    function automatic int row_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int c_data_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/result_row_select.sv
// Combinational N:1 selector of one result row (or column when
// SUM_STATIONARY_DRAIN_TRANSPOSE_EN is defined); output is zero when not valid.
module result_row_select #(
    parameter int N  = 4,
    parameter int W  = 18,
    parameter int IW = 2
) (
    input  logic [N-1:0][N-1:0][W-1:0] mat_i,
    input  logic [IW-1:0]              sel_i,
    input  logic                       valid_i,
    output logic [N-1:0][W-1:0]        data_o
);

    always_comb begin
        data_o = '0;
        if (valid_i) begin
            for (int j = 0; j < N; j++) begin
`ifdef SUM_STATIONARY_DRAIN_TRANSPOSE_EN
                data_o[j] = mat_i[j][sel_i];
`else
                data_o[j] = mat_i[sel_i][j];
`endif
            end
        end
    end

endmodule

// File: rtl/sum_stationary_drain.sv
// Captures the engine's C array, clears the engine, and streams the result one row per beat.
// Build option SUM_STATIONARY_DRAIN_TRANSPOSE_EN streams columns instead of rows.
module sum_stationary_drain
    import sum_stationary_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  N            = 4,
    parameter int  C_DATA_WIDTH = c_data_width(DATA_WIDTH, N),
    localparam int IW           = row_idx_width(N)
) (
    input  logic                                     clk,
    input  logic                                     reset_ni,
    input  logic                                     mm_valid_i,
    input  logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0]    c_i,
    output logic                                     mm_clear_o,
    output logic                                     row_valid_o,
    input  logic                                     row_ready_i,
    output logic [N-1:0][C_DATA_WIDTH-1:0]           row_data_o,
    output logic [IW-1:0]                            row_idx_o,
    output logic                                     row_last_o,
    output logic                                     busy_o
);

    drain_state_e                          state_q, state_d;
    logic [IW-1:0]                         row_q, row_d;
    logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0] mat_q, mat_d;

    logic sending, last, hs, cap;

    assign sending = (state_q == SEND);
    assign last    = sending && (row_q == IW'(N - 1));
    assign hs      = sending && row_ready_i;
    // Gated by reset so the engine is never cleared while this block is held in reset.
    assign cap     = reset_ni && mm_valid_i && (!sending || (hs && last));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        mat_d   = mat_q;
        if (cap) begin
            mat_d   = c_i;
            row_d   = '0;
            state_d = SEND;
        end else if (hs) begin
            if (last) begin
                row_d   = '0;
                state_d = IDLE;
            end else begin
                row_d = row_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Buffer contents are don't-care after reset; the selector masks them while idle.
    always_ff @(posedge clk) begin
        mat_q <= mat_d;
    end

    result_row_select #(
        .N  (N),
        .W  (C_DATA_WIDTH),
        .IW (IW)
    ) u_row_select (
        .mat_i   (mat_q),
        .sel_i   (row_q),
        .valid_i (sending),
        .data_o  (row_data_o)
    );

    assign mm_clear_o  = cap;
    assign row_valid_o = sending;
    assign row_idx_o   = row_q;
    assign row_last_o  = last;
    assign busy_o      = sending;

endmodule

// File: tb/tb_sum_stationary_drain.sv
// Bench for sum_stationary_drain: beat-queue reference model plus directed and random traffic.
module tb_sum_stationary_drain;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 18;

    typedef logic [N-1:0][CW-1:0]        row_t;
    typedef logic [N-1:0][N-1:0][CW-1:0] mat_t;
    typedef struct {
        int   idx;
        row_t data;
    } beat_t;

    logic       clk;
    logic       reset_ni;
    logic       mm_valid_i;
    mat_t       c_i;
    logic       mm_clear_o;
    logic       row_valid_o;
    logic       row_ready_i;
    row_t       row_data_o;
    logic [1:0] row_idx_o;
    logic       row_last_o;
    logic       busy_o;

    sum_stationary_drain #(
        .DATA_WIDTH (DW),
        .N          (N)
    ) dut (
        .clk         (clk),
        .reset_ni    (reset_ni),
        .mm_valid_i  (mm_valid_i),
        .c_i         (c_i),
        .mm_clear_o  (mm_clear_o),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .row_data_o  (row_data_o),
        .row_idx_o   (row_idx_o),
        .row_last_o  (row_last_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Element j of beat k for the 10*i+j test matrix, in the order the build streams it.
    function automatic int elem(input int k, input int j);
`ifdef SUM_STATIONARY_DRAIN_TRANSPOSE_EN
        return 10 * j + k;
`else
        return 10 * k + j;
`endif
    endfunction

    // Reference model: pending beats queue; capture whenever the engine is valid
    // and the queue is empty or its final beat is handed off this cycle.
    always @(negedge clk) begin
        bit    ev, el, h, capx;
        beat_t b;
        if (!reset_ni) begin
            q.delete();
            chk("rst_valid", row_valid_o, 0);
            chk("rst_busy",  busy_o, 0);
            chk("rst_clear", mm_clear_o, 0);
            chk("rst_last",  row_last_o, 0);
            chk("rst_idx",   row_idx_o, 0);
            chk("rst_data",  row_data_o, 0);
        end else begin
            ev   = (q.size() > 0);
            el   = ev && (q[0].idx == N - 1);
            h    = ev && row_ready_i;
            capx = mm_valid_i && (!ev || (h && el));
            chk("valid", row_valid_o, ev);
            chk("busy",  busy_o, ev);
            chk("clear", mm_clear_o, capx);
            chk("last",  row_last_o, el);
            chk("idx",   row_idx_o, ev ? q[0].idx : 0);
            chk("data",  row_data_o, ev ? q[0].data : '0);
            if (h) void'(q.pop_front());
            if (capx) begin
                for (int k = 0; k < N; k++) begin
                    b.idx = k;
                    for (int j = 0; j < N; j++) begin
`ifdef SUM_STATIONARY_DRAIN_TRANSPOSE_EN
                        b.data[j] = c_i[j][k];
`else
                        b.data[j] = c_i[k][j];
`endif
                    end
                    q.push_back(b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_i[i][j] = CW'(base + 10 * i + j);
        mm_valid_i = 1'b1;
    endtask

    task automatic wait_clear();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = mm_clear_o;
            step();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL clear_timeout: got no mm_clear_o expected one within 20 cycles");
        end
        mm_valid_i = 1'b0;
    endtask

    task automatic drain();
        row_ready_i = 1'b1;
        mm_valid_i  = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        bit clr;
        reset_ni    = 1'b1;
        mm_valid_i  = 1'b0;
        row_ready_i = 1'b0;
        c_i         = '0;
        #1 reset_ni = 1'b0;
        @(posedge clk);
        #1 reset_ni = 1'b1;

        // Basic drain
        load(0);
        row_ready_i = 1'b1;
        @(negedge clk);
        chk("lit_cap_clear", mm_clear_o, 1);
        chk("lit_cap_valid", row_valid_o, 0);
        step();
        mm_valid_i = 1'b0;
        @(negedge clk);
        chk("lit_r0_idx",  row_idx_o, 0);
        chk("lit_r0_d1",   row_data_o[1], elem(0, 1));
        chk("lit_r0_last", row_last_o, 0);
        chk("lit_r0_clr",  mm_clear_o, 0);
        step(); step(); step();
        @(negedge clk);
        chk("lit_r3_last", row_last_o, 1);
        chk("lit_r3_idx",  row_idx_o, 3);
        chk("lit_r3_d3",   row_data_o[3], elem(3, 3));
        step();
        @(negedge clk);
        chk("lit_idle_busy", busy_o, 0);

        // Backpressure on row 1
        load(0);
        step();
        mm_valid_i = 1'b0;
        step();
        row_ready_i = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("lit_bp_idx",   row_idx_o, 1);
        chk("lit_bp_d0",    row_data_o[0], elem(1, 0));
        chk("lit_bp_valid", row_valid_o, 1);
        drain();

        // Held engine: second result waits for the last handshake
        load(0);
        step();
        mm_valid_i = 1'b0;
        step();
        load(100);
        @(negedge clk);
        chk("lit_hold_noclr", mm_clear_o, 0);
        step(); step();
        @(negedge clk);
        chk("lit_hold_clr", mm_clear_o, 1);
        step();
        mm_valid_i = 1'b0;
        @(negedge clk);
        chk("lit_b2b_valid", row_valid_o, 1);
        chk("lit_b2b_idx",   row_idx_o, 0);
        chk("lit_b2b_d0",    row_data_o[0], 100);
        drain();

        // Wide values
        c_i        = '1;
        mm_valid_i = 1'b1;
        step();
        mm_valid_i = 1'b0;
        @(negedge clk);
        chk("lit_wide", row_data_o, {N{18'h3FFFF}});
        drain();

        // Async reset mid row 2
        load(0);
        step();
        mm_valid_i = 1'b0;
        step(); step();
        #2 reset_ni = 1'b0;
        #1;
        chk("lit_ar_valid", row_valid_o, 0);
        chk("lit_ar_busy",  busy_o, 0);
        chk("lit_ar_data",  row_data_o, 0);
        mm_valid_i = 1'b1;
        #1;
        chk("lit_ar_clr", mm_clear_o, 0);
        @(posedge clk);
        #1 reset_ni = 1'b1;
        wait_clear();
        @(negedge clk);
        chk("lit_restart_idx",   row_idx_o, 0);
        chk("lit_restart_valid", row_valid_o, 1);
        drain();

        // Random traffic: engine holds its result until cleared
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            clr = mm_clear_o;
            step();
            if (clr) begin
                mm_valid_i = 1'b0;
            end else if (!mm_valid_i && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        c_i[i][j] = CW'($urandom);
                mm_valid_i = 1'b1;
            end
            row_ready_i = ($urandom_range(0, 3) != 0);
        end
        if (mm_valid_i) wait_clear();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
